// File: rtl/i2c_master_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the I2C master top.
// The master modport is the arbiter's view. The slave modport is the
// surrounding system: the requesters plus the I2C master's response lines.
interface i2c_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
);
  // requester side
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic                      to_err;
  logic                      busy;
  // I2C master side
  logic                      m_start;
  logic [ADDR_W-1:0]         m_addr;
  logic                      m_rw;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_abort;
  logic                      m_done;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_nack;

  modport master (
    input  req, req_addr, req_rw, req_wdata, m_done, m_rdata, m_nack,
    output gnt, done, rdata, err, to_err, busy,
           m_start, m_addr, m_rw, m_wdata, m_abort
  );

  modport slave (
    output req, req_addr, req_rw, req_wdata, m_done, m_rdata, m_nack,
    input  gnt, done, rdata, err, to_err, busy,
           m_start, m_addr, m_rw, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one I2C master between NUM_REQ requesters
// (index 0 = CPU, index 1 = user module). It runs one single-byte command
// per grant through a start/done handshake and returns the read data and
// status to the winner. All outputs are registered.
// Optional build macro: I2C_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts the master after TIMEOUT_CYCLES cycles without m_done.
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  i2c_master_arbiter_if.master  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]    winner_reg, winner_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]  done_reg, done_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic                to_err_reg, to_err_next;
  logic                busy_reg, busy_next;
  logic                m_start_reg, m_start_next;
  logic                m_abort_reg, m_abort_next;
  logic [ADDR_W-1:0]   m_addr_reg, m_addr_next;
  logic                m_rw_reg, m_rw_next;
  logic [DATA_W-1:0]   m_wdata_reg, m_wdata_next;

  // Per-requester views of the packed command fields
  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_reg, to_cnt_next;
  logic             to_expire;
  // Expiry fires on the TIMEOUT_CYCLES-th WAIT cycle (counter starts at 0)
  assign to_expire = (to_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Round-robin pick: first set req bit searching upward from rr_ptr, wrapping
  logic             any_req;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand_idx;
  int               cand;
  always_comb begin
    any_req  = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_reg) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_req && bus.req[cand_idx]) begin
        any_req = 1'b1;
        pick    = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    winner_next  = winner_reg;
    gnt_next     = '0;
    done_next    = '0;
    m_start_next = 1'b0;
    m_abort_next = 1'b0;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    to_err_next  = to_err_reg;
    m_addr_next  = m_addr_reg;
    m_rw_next    = m_rw_reg;
    m_wdata_next = m_wdata_reg;
`ifdef I2C_ARB_TIMEOUT_EN
    to_cnt_next  = to_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next   = ISSUE;
          winner_next  = pick;
          gnt_next     = ONE_HOT0 << pick;
          m_start_next = 1'b1;
          m_addr_next  = addr_arr[pick];
          m_rw_next    = bus.req_rw[pick];
          m_wdata_next = wdata_arr[pick];
        end
      end
      ISSUE: begin
        // m_done cannot legally arrive here, so it is not looked at
        state_next = WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
        to_cnt_next = '0;
`endif
      end
      WAIT: begin
        // A completion in the expiry cycle takes priority over the timeout
        if (bus.m_done) begin
          state_next  = RESP;
          done_next   = ONE_HOT0 << winner_reg;
          rdata_next  = m_rw_reg ? bus.m_rdata : '0;
          err_next    = bus.m_nack;
          to_err_next = 1'b0;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (to_expire) begin
          state_next   = RESP;
          done_next    = ONE_HOT0 << winner_reg;
          m_abort_next = 1'b1;
          rdata_next   = '0;
          err_next     = 1'b1;
          to_err_next  = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
`endif
      end
      RESP: begin
        state_next  = IDLE;
        rr_ptr_next = (winner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : winner_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset wipes any in-flight command silently
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      winner_reg  <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      to_err_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      m_start_reg <= 1'b0;
      m_abort_reg <= 1'b0;
      m_addr_reg  <= '0;
      m_rw_reg    <= 1'b0;
      m_wdata_reg <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      to_cnt_reg  <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      winner_reg  <= winner_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      to_err_reg  <= to_err_next;
      busy_reg    <= busy_next;
      m_start_reg <= m_start_next;
      m_abort_reg <= m_abort_next;
      m_addr_reg  <= m_addr_next;
      m_rw_reg    <= m_rw_next;
      m_wdata_reg <= m_wdata_next;
`ifdef I2C_ARB_TIMEOUT_EN
      to_cnt_reg  <= to_cnt_next;
`endif
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.done    = done_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.err     = err_reg;
  assign bus.to_err  = to_err_reg;
  assign bus.busy    = busy_reg;
  assign bus.m_start = m_start_reg;
  assign bus.m_abort = m_abort_reg;
  assign bus.m_addr  = m_addr_reg;
  assign bus.m_rw    = m_rw_reg;
  assign bus.m_wdata = m_wdata_reg;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter. The bench plays both the requesters
// and the I2C master. With I2C_ARB_TIMEOUT_EN defined it also exercises the
// watchdog, using TIMEOUT_CYCLES = 16.
module tb_i2c_master_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int TO_CYC  = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  i2c_master_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  i2c_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle past the edge before sampling/driving
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_fields(input int r, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    bus.req_addr[r*ADDR_W +: ADDR_W]  = a;
    bus.req_rw[r]                     = rw;
    bus.req_wdata[r*DATA_W +: DATA_W] = wd;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"},     32'(bus.gnt),     32'h0);
    check({tag, ".done"},    32'(bus.done),    32'h0);
    check({tag, ".rdata"},   32'(bus.rdata),   32'h0);
    check({tag, ".err"},     32'(bus.err),     32'h0);
    check({tag, ".to_err"},  32'(bus.to_err),  32'h0);
    check({tag, ".busy"},    32'(bus.busy),    32'h0);
    check({tag, ".m_start"}, 32'(bus.m_start), 32'h0);
    check({tag, ".m_abort"}, 32'(bus.m_abort), 32'h0);
    check({tag, ".m_addr"},  32'(bus.m_addr),  32'h0);
    check({tag, ".m_rw"},    32'(bus.m_rw),    32'h0);
    check({tag, ".m_wdata"}, 32'(bus.m_wdata), 32'h0);
  endtask

  // One full command: grant, dly cycles until the master's m_done, then response.
  // The master answers in cycle (m_start cycle + dly).
  task automatic run_txn(input string name, input logic [1:0] req_val, input logic [1:0] exp_gnt,
                         input logic [6:0] exp_addr, input logic exp_rw, input logic [7:0] exp_wd,
                         input int dly, input logic [7:0] rd, input logic nack, input logic keep_req);
    logic [7:0] exp_rd;
    exp_rd  = exp_rw ? rd : 8'h00;
    bus.req = req_val;
    tick();
    check({name, ".gnt"},      32'(bus.gnt),     32'(exp_gnt));
    check({name, ".m_start"},  32'(bus.m_start), 32'h1);
    check({name, ".busy"},     32'(bus.busy),    32'h1);
    check({name, ".m_addr"},   32'(bus.m_addr),  32'(exp_addr));
    check({name, ".m_rw"},     32'(bus.m_rw),    32'(exp_rw));
    check({name, ".m_wdata"},  32'(bus.m_wdata), 32'(exp_wd));
    check({name, ".rd_hold"},  32'(bus.rdata),   32'(last_rdata));
    if (!keep_req) begin
      bus.req       = '0;
      bus.req_addr  = '1;
      bus.req_wdata = '1;
      bus.req_rw    = ~bus.req_rw;
    end
    for (int k = 0; k < dly; k++) begin
      tick();
      check({name, ".gnt_pulse"}, 32'(bus.gnt),     32'h0);
      check({name, ".start_pls"}, 32'(bus.m_start), 32'h0);
      check({name, ".early_done"},32'(bus.done),    32'h0);
      check({name, ".no_abort"},  32'(bus.m_abort), 32'h0);
    end
    bus.m_done  = 1'b1;
    bus.m_rdata = rd;
    bus.m_nack  = nack;
    tick();
    bus.m_done  = 1'b0;
    bus.m_rdata = 8'hEE;
    bus.m_nack  = ~nack;
    check({name, ".done"},     32'(bus.done),    32'(exp_gnt));
    check({name, ".rdata"},    32'(bus.rdata),   32'(exp_rd));
    check({name, ".err"},      32'(bus.err),     32'(nack));
    check({name, ".to_err"},   32'(bus.to_err),  32'h0);
    check({name, ".m_abort"},  32'(bus.m_abort), 32'h0);
    check({name, ".busy_rsp"}, 32'(bus.busy),    32'h1);
    check({name, ".addr_hold"},32'(bus.m_addr),  32'(exp_addr));
    check({name, ".wd_hold"},  32'(bus.m_wdata), 32'(exp_wd));
    $display("txn %s: gnt=%b addr=0x%0h rw=%0d wdata=0x%0h rdata=0x%0h err=%0d",
             name, exp_gnt, exp_addr, exp_rw, exp_wd, bus.rdata, bus.err);
    tick();
    check({name, ".done_pulse"}, 32'(bus.done),  32'h0);
    check({name, ".idle"},       32'(bus.busy),  32'h0);
    check({name, ".rdata_keep"}, 32'(bus.rdata), 32'(exp_rd));
    check({name, ".err_keep"},   32'(bus.err),   32'(nack));
    last_rdata = exp_rd;
  endtask

  initial begin
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_rw    = '0;
    bus.req_wdata = '0;
    bus.m_done    = 1'b0;
    bus.m_rdata   = '0;
    bus.m_nack    = 1'b0;
    tick();
    tick();
    check_zero("reset");
    RST = 1'b0;

    // CPU write, master answers 3 cycles after m_start
    set_fields(0, 7'h50, 1'b0, 8'hA5);
    run_txn("cpu_wr", 2'b01, 2'b01, 7'h50, 1'b0, 8'hA5, 3, 8'hDE, 1'b0, 1'b0);

    // User read
    set_fields(1, 7'h3C, 1'b1, 8'h00);
    run_txn("usr_rd", 2'b10, 2'b10, 7'h3C, 1'b1, 8'h00, 2, 8'h5A, 1'b0, 1'b0);

    // Both requesting continuously from reset: 0,1,0,1
    RST = 1'b1;
    tick();
    RST = 1'b0;
    last_rdata = 8'h00;
    set_fields(0, 7'h11, 1'b0, 8'h33);
    set_fields(1, 7'h22, 1'b1, 8'h44);
    run_txn("rr0", 2'b11, 2'b01, 7'h11, 1'b0, 8'h33, 1, 8'h55, 1'b0, 1'b1);
    run_txn("rr1", 2'b11, 2'b10, 7'h22, 1'b1, 8'h44, 2, 8'h66, 1'b0, 1'b1);
    run_txn("rr2", 2'b11, 2'b01, 7'h11, 1'b0, 8'h33, 1, 8'h77, 1'b0, 1'b1);
    run_txn("rr3", 2'b11, 2'b10, 7'h22, 1'b1, 8'h44, 3, 8'h88, 1'b0, 1'b1);
    bus.req = '0;

    // NACK on a write to 0x7F
    set_fields(0, 7'h7F, 1'b0, 8'hC0);
    run_txn("nack", 2'b01, 2'b01, 7'h7F, 1'b0, 8'hC0, 2, 8'h12, 1'b1, 1'b0);

    // Reset while waiting on the master; rr_ptr is 1 at this point
    set_fields(0, 7'h12, 1'b1, 8'h34);
    bus.req = 2'b01;
    tick();
    check("rst.pre_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_zero("rst_wait");
    // A stale completion after reset must not produce a done
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    check("rst.stale_done", 32'(bus.done), 32'h0);
    check("rst.stale_busy", 32'(bus.busy), 32'h0);
    last_rdata = 8'h00;
    // rr_ptr back at 0: with both requesting, requester 0 must win
    set_fields(0, 7'h21, 1'b1, 8'h00);
    set_fields(1, 7'h31, 1'b0, 8'h77);
    run_txn("rr_after_rst", 2'b11, 2'b01, 7'h21, 1'b1, 8'h00, 2, 8'h99, 1'b0, 1'b0);

`ifdef I2C_ARB_TIMEOUT_EN
    // No m_done: abort 16 cycles after WAIT entry
    set_fields(1, 7'h0F, 1'b1, 8'h00);
    bus.req = 2'b10;
    tick();
    check("to.gnt", 32'(bus.gnt), 32'h2);
    bus.req     = '0;
    bus.m_rdata = 8'hC3;
    for (int k = 0; k < TO_CYC; k++) begin
      tick();
      check("to.no_abort_yet", 32'(bus.m_abort), 32'h0);
      check("to.no_done_yet",  32'(bus.done),    32'h0);
    end
    tick();
    check("to.m_abort", 32'(bus.m_abort), 32'h1);
    check("to.done",    32'(bus.done),    32'h2);
    check("to.err",     32'(bus.err),     32'h1);
    check("to.to_err",  32'(bus.to_err),  32'h1);
    check("to.rdata",   32'(bus.rdata),   32'h0);
    $display("txn timeout: gnt=10 addr=0x0f abort=%0d err=%0d to_err=%0d", bus.m_abort, bus.err, bus.to_err);
    tick();
    check("to.abort_pulse", 32'(bus.m_abort), 32'h0);
    check("to.to_err_keep", 32'(bus.to_err),  32'h1);
    check("to.idle",        32'(bus.busy),    32'h0);
    last_rdata = 8'h00;
    set_fields(0, 7'h44, 1'b1, 8'h00);
    run_txn("after_to", 2'b01, 2'b01, 7'h44, 1'b1, 8'h00, 10, 8'hB7, 1'b0, 1'b0);
`else
    // Without the watchdog a slow master is simply waited on
    set_fields(1, 7'h0F, 1'b1, 8'h00);
    run_txn("long_wait", 2'b10, 2'b10, 7'h0F, 1'b1, 8'h00, 20, 8'h3C, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
